// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared timing constants and helpers for the VGA raster generator.
//   - VGA640_*  : 640x480@60 (25.175 MHz pixel rate) timing set, negative syncs
//   - SVGA800_* : 800x600@60 (40 MHz pixel rate) timing set, positive syncs
//   - axis_total / sync_start / sync_end : derived positions along one axis,
//     with the axis laid out as active, front porch, sync, back porch.
package vga_timing_pkg;

  localparam int   VGA640_H_ACTIVE = 640;
  localparam int   VGA640_H_FP     = 16;
  localparam int   VGA640_H_SYNC   = 96;
  localparam int   VGA640_H_BP     = 48;
  localparam int   VGA640_V_ACTIVE = 480;
  localparam int   VGA640_V_FP     = 10;
  localparam int   VGA640_V_SYNC   = 2;
  localparam int   VGA640_V_BP     = 33;
  localparam logic VGA640_HS_POL   = 1'b0;
  localparam logic VGA640_VS_POL   = 1'b0;

  localparam int   SVGA800_H_ACTIVE = 800;
  localparam int   SVGA800_H_FP     = 40;
  localparam int   SVGA800_H_SYNC   = 128;
  localparam int   SVGA800_H_BP     = 88;
  localparam int   SVGA800_V_ACTIVE = 600;
  localparam int   SVGA800_V_FP     = 1;
  localparam int   SVGA800_V_SYNC   = 4;
  localparam int   SVGA800_V_BP     = 23;
  localparam logic SVGA800_HS_POL   = 1'b1;
  localparam logic SVGA800_VS_POL   = 1'b1;

  // Number of counts in one full period of an axis.
  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // First count at which sync is asserted.
  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  // First count after sync has been deasserted again (exclusive bound).
  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One raster axis (horizontal or vertical): a wrapping position counter
// plus registered active/sync flags that always describe the current count.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   step       : advance by one count this clk (wraps at the end of the axis)
//   clear      : force the count to 0 this clk (wins over step)
//   count      : current position, W bits
//   wrap       : count is the last position of the axis (combinational)
//   active     : count lies in the visible region (registered)
//   sync       : sync output at polarity POL (registered)
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE = 640,
  parameter int   FP     = 16,
  parameter int   SYNC   = 96,
  parameter int   BP     = 48,
  parameter logic POL    = 1'b0,
  parameter int   W      = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         clear,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         active,
  output logic         sync
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_BEGIN = W'(sync_start(ACTIVE, FP));
  localparam logic [W-1:0] SYNC_STOP  = W'(sync_end(ACTIVE, FP, SYNC));

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_widths
    $error("vga_axis_counter: every timing width must be at least 1");
  end
  if (W < 1 || W > 30 || (1 << W) < TOTAL) begin : g_bad_counter
    $error("vga_axis_counter: counter width W cannot hold TOTAL-1");
  end

  logic [W-1:0] count_next;

  assign wrap = (count == LAST);

  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (step) begin
      count_next = wrap ? '0 : count + 1'b1;
    end
  end

  // The flags are decoded from the next count so they land on the same edge
  // as the count itself and never lag it by a cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      active <= 1'b1;
      sync   <= ~POL;
    end else begin
      count  <= count_next;
      active <= (count_next < ACT_END);
      sync   <= ((count_next >= SYNC_BEGIN) && (count_next < SYNC_STOP)) ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA raster timing generator with run/freeze, resync, line,
// frame and vblank strobes and a completed-frame counter.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   pix_en       : pixel-rate enable, one clk wide (may be high every clk)
//   run          : 1 = advance on pix_en, 0 = freeze everything
//   resync       : force the raster to (0,0) on the next clk
//   hsync, vsync : sync outputs at polarity HS_POL / VS_POL
//   active       : current pixel is visible
//   x, y         : raw horizontal / vertical counters, including blanking
//   line_start   : one-clk pulse when x becomes 0
//   frame_start  : one-clk pulse when (x,y) becomes (0,0)
//   vblank_start : one-clk pulse when (x,y) becomes (0,V_ACTIVE)
//   frame_count  : frames completed by advancing, wraps modulo 2^FRAME_W
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VGA640_H_ACTIVE,
  parameter int   H_FP     = VGA640_H_FP,
  parameter int   H_SYNC   = VGA640_H_SYNC,
  parameter int   H_BP     = VGA640_H_BP,
  parameter int   V_ACTIVE = VGA640_V_ACTIVE,
  parameter int   V_FP     = VGA640_V_FP,
  parameter int   V_SYNC   = VGA640_V_SYNC,
  parameter int   V_BP     = VGA640_V_BP,
  parameter logic HS_POL   = VGA640_HS_POL,
  parameter logic VS_POL   = VGA640_VS_POL,
  parameter int   X_W      = 10,
  parameter int   Y_W      = 10,
  parameter int   FRAME_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  input  logic               run,
  input  logic               resync,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic               line_start,
  output logic               frame_start,
  output logic               vblank_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam logic [Y_W-1:0] V_LAST_VISIBLE = Y_W'(V_ACTIVE - 1);

  logic advance;
  logic h_wrap;
  logic v_wrap;
  logic h_active;
  logic v_active;
  logic resync_q;

  assign advance = pix_en & run & ~resync;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL),
    .W      (X_W)
  ) u_h_axis (
    .clk    (clk),
    .rst    (rst),
    .step   (advance),
    .clear  (resync),
    .count  (x),
    .wrap   (h_wrap),
    .active (h_active),
    .sync   (hsync)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL),
    .W      (Y_W)
  ) u_v_axis (
    .clk    (clk),
    .rst    (rst),
    .step   (advance & h_wrap),
    .clear  (resync),
    .count  (y),
    .wrap   (v_wrap),
    .active (v_active),
    .sync   (vsync)
  );

  // Both axis flags are registers, so the product is glitch-free and moves
  // on the same edge as the counters.
  assign active = h_active & v_active;

  // Strobes are decoded from the current position and the action about to be
  // taken, so each pulse coincides with the edge that produces its counter
  // value. resync_q stops a resync held over several clks from re-pulsing
  // while the raster sits at (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      frame_count  <= '0;
      resync_q     <= 1'b0;
    end else begin
      resync_q     <= resync;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      if (resync) begin
        if (!resync_q) begin
          line_start  <= 1'b1;
          frame_start <= 1'b1;
        end
      end else if (advance && h_wrap) begin
        line_start   <= 1'b1;
        frame_start  <= v_wrap;
        vblank_start <= (y == V_LAST_VISIBLE);
        if (v_wrap) begin
          frame_count <= frame_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Directed bench for vga_timing_gen using three instances:
//   dut_a : default 640x480 timing, pix_en every 4th clk (line timing)
//   dut_c : 14-pixel lines with the default 525-line vertical timing, pix_en
//           every clk (frame wrap, vblank, vsync placement)
//   dut_b : 14x7 raster, positive syncs, pix_en every clk (frame count,
//           resync, freeze, reset priority)
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        pe_a, run_a, rs_a;
  logic        hs_a, vs_a, act_a, ls_a, fs_a, vb_a;
  logic [9:0]  x_a, y_a;
  logic [15:0] fc_a;

  logic        pe_b, run_b, rs_b;
  logic        hs_b, vs_b, act_b, ls_b, fs_b, vb_b;
  logic [3:0]  x_b;
  logic [2:0]  y_b;
  logic [15:0] fc_b;

  logic        pe_c, run_c, rs_c;
  logic        hs_c, vs_c, act_c, ls_c, fs_c, vb_c;
  logic [3:0]  x_c;
  logic [9:0]  y_c;
  logic [15:0] fc_c;

  int total = 0;
  int bad   = 0;

  int hs_low, hs_first, hs_rise, act_fall, ls_n, ls_x;
  int vb_n, vb_x, vb_y, vb_act, vs_low, vs_min, vs_max, fs_n;
  int hs_hi, hs_hi_first, frozen_bad;
  logic prev_hs, prev_act;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst), .pix_en(pe_a), .run(run_a), .resync(rs_a),
    .hsync(hs_a), .vsync(vs_a), .active(act_a), .x(x_a), .y(y_a),
    .line_start(ls_a), .frame_start(fs_a), .vblank_start(vb_a), .frame_count(fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .X_W(4), .Y_W(3), .FRAME_W(16)
  ) dut_b (
    .clk(clk), .rst(rst), .pix_en(pe_b), .run(run_b), .resync(rs_b),
    .hsync(hs_b), .vsync(vs_b), .active(act_b), .x(x_b), .y(y_b),
    .line_start(ls_b), .frame_start(fs_b), .vblank_start(vb_b), .frame_count(fc_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .HS_POL(1'b0), .VS_POL(1'b0), .X_W(4), .Y_W(10), .FRAME_W(16)
  ) dut_c (
    .clk(clk), .rst(rst), .pix_en(pe_c), .run(run_c), .resync(rs_c),
    .hsync(hs_c), .vsync(vs_c), .active(act_c), .x(x_c), .y(y_c),
    .line_start(ls_c), .frame_start(fs_c), .vblank_start(vb_c), .frame_count(fc_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives reset and the three pixel enables, then advances one clk.
  task automatic applyStimulus(input logic r, input logic ea, input logic eb, input logic ec);
    rst  = r;
    pe_a = ea;
    pe_b = eb;
    pe_c = ec;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    pe_a = 1'b1; pe_b = 1'b1; pe_c = 1'b1;
    run_a = 1'b1; run_b = 1'b1; run_c = 1'b1;
    rs_a = 1'b0; rs_b = 1'b0; rs_c = 1'b0;

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("rst_x_a", 32'(x_a), 0);
    checkOutput("rst_y_a", 32'(y_a), 0);
    checkOutput("rst_active_a", 32'(act_a), 1);
    checkOutput("rst_hsync_a", 32'(hs_a), 1);
    checkOutput("rst_vsync_a", 32'(vs_a), 1);
    checkOutput("rst_fc_a", 32'(fc_a), 0);
    checkOutput("rst_strobes_a", 32'({ls_a, fs_a, vb_a}), 0);
    checkOutput("rst_hsync_b", 32'(hs_b), 0);
    checkOutput("rst_vsync_b", 32'(vs_b), 0);
    checkOutput("rst_active_c", 32'(act_c), 1);

    $display("[TB] default line timing, pix_en every 4th clk");
    rst = 1'b0; pe_b = 1'b0; pe_c = 1'b0;
    hs_low = 0; hs_first = -1; hs_rise = -1; act_fall = -1; ls_n = 0; ls_x = -1;
    prev_hs = 1'b1; prev_act = 1'b1;
    for (int p = 0; p < 800; p++) begin
      for (int k = 0; k < 4; k++) begin
        pe_a = (k == 0);
        tick();
        if (!hs_a) begin
          hs_low++;
          if (hs_first < 0) hs_first = int'(x_a);
        end
        if (hs_a && !prev_hs && hs_rise < 0) hs_rise = int'(x_a);
        if (!act_a && prev_act && act_fall < 0) act_fall = int'(x_a);
        if (ls_a) begin
          ls_n++;
          ls_x = int'(x_a);
        end
        prev_hs  = hs_a;
        prev_act = act_a;
      end
    end
    pe_a = 1'b0;
    checkOutput("hsync_low_clks", 32'(hs_low), 384);
    checkOutput("hsync_first_x", 32'(hs_first), 656);
    checkOutput("hsync_rise_x", 32'(hs_rise), 752);
    checkOutput("active_fall_x", 32'(act_fall), 640);
    checkOutput("line_start_count", 32'(ls_n), 1);
    checkOutput("line_start_x", 32'(ls_x), 0);
    checkOutput("line_end_x_a", 32'(x_a), 0);
    checkOutput("line_end_y_a", 32'(y_a), 1);
    checkOutput("line_end_fc_a", 32'(fc_a), 0);

    $display("[TB] frame wrap, 14x525 raster");
    pe_c = 1'b1;
    vb_n = 0; vb_x = -1; vb_y = -1; vb_act = -1; vs_low = 0; vs_min = 9999; vs_max = -1; fs_n = 0;
    for (int i = 0; i < 7349; i++) begin
      tick();
      if (vb_c) begin
        vb_n++;
        vb_x = int'(x_c);
        vb_y = int'(y_c);
        vb_act = int'(act_c);
      end
      if (!vs_c) begin
        vs_low++;
        if (int'(y_c) < vs_min) vs_min = int'(y_c);
        if (int'(y_c) > vs_max) vs_max = int'(y_c);
      end
      if (fs_c) fs_n++;
    end
    checkOutput("last_x_c", 32'(x_c), 13);
    checkOutput("last_y_c", 32'(y_c), 524);
    checkOutput("pre_wrap_fc_c", 32'(fc_c), 0);
    checkOutput("pre_wrap_fs_count", 32'(fs_n), 0);
    checkOutput("vblank_count", 32'(vb_n), 1);
    checkOutput("vblank_x", 32'(vb_x), 0);
    checkOutput("vblank_y", 32'(vb_y), 480);
    checkOutput("vblank_active", 32'(vb_act), 0);
    checkOutput("vsync_low_clks", 32'(vs_low), 28);
    checkOutput("vsync_first_line", 32'(vs_min), 490);
    checkOutput("vsync_last_line", 32'(vs_max), 491);
    tick();
    checkOutput("wrap_x_c", 32'(x_c), 0);
    checkOutput("wrap_y_c", 32'(y_c), 0);
    checkOutput("wrap_fs_c", 32'(fs_c), 1);
    checkOutput("wrap_ls_c", 32'(ls_c), 1);
    checkOutput("wrap_fc_c", 32'(fc_c), 1);
    tick();
    checkOutput("post_wrap_fs_c", 32'(fs_c), 0);
    checkOutput("post_wrap_x_c", 32'(x_c), 1);
    checkOutput("post_wrap_fc_c", 32'(fc_c), 1);
    pe_c = 1'b0;

    $display("[TB] small raster, three frames");
    pe_b = 1'b1;
    hs_hi = 0; hs_hi_first = -1; fs_n = 0;
    for (int i = 0; i < 294; i++) begin
      tick();
      if (i < 14 && hs_b) begin
        hs_hi++;
        if (hs_hi_first < 0) hs_hi_first = int'(x_b);
      end
      if (fs_b) fs_n++;
    end
    checkOutput("small_hsync_high_clks", 32'(hs_hi), 2);
    checkOutput("small_hsync_first_x", 32'(hs_hi_first), 10);
    checkOutput("small_frame_starts", 32'(fs_n), 3);
    checkOutput("small_fc", 32'(fc_b), 3);
    checkOutput("small_x", 32'(x_b), 0);
    checkOutput("small_y", 32'(y_b), 0);

    $display("[TB] resync");
    for (int i = 0; i < 33; i++) tick();
    checkOutput("pre_resync_x", 32'(x_b), 5);
    checkOutput("pre_resync_y", 32'(y_b), 2);
    rs_b = 1'b1;
    tick();
    rs_b = 1'b0;
    checkOutput("resync_xy", 32'({x_b, y_b}), 0);
    checkOutput("resync_ls", 32'(ls_b), 1);
    checkOutput("resync_fs", 32'(fs_b), 1);
    checkOutput("resync_vb", 32'(vb_b), 0);
    checkOutput("resync_fc", 32'(fc_b), 3);
    tick();
    checkOutput("after_resync_x", 32'(x_b), 1);
    checkOutput("after_resync_strobes", 32'({ls_b, fs_b}), 0);

    $display("[TB] freeze");
    for (int i = 0; i < 80; i++) tick();
    checkOutput("freeze_pos_x", 32'(x_b), 11);
    checkOutput("freeze_pos_y", 32'(y_b), 5);
    checkOutput("freeze_pos_hsync", 32'(hs_b), 1);
    checkOutput("freeze_pos_vsync", 32'(vs_b), 1);
    checkOutput("freeze_pos_active", 32'(act_b), 0);
    run_b = 1'b0;
    frozen_bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (x_b != 4'd11 || y_b != 3'd5 || hs_b != 1'b1 || vs_b != 1'b1 || act_b != 1'b0 ||
          fc_b != 16'd3 || ls_b || fs_b || vb_b) frozen_bad++;
    end
    checkOutput("frozen_changes", 32'(frozen_bad), 0);
    run_b = 1'b1;
    tick();
    checkOutput("resume_x", 32'(x_b), 12);
    checkOutput("resume_y", 32'(y_b), 5);
    checkOutput("resume_hsync", 32'(hs_b), 0);

    $display("[TB] reset with resync");
    rs_b = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    rs_b = 1'b0;
    rst = 1'b0;
    checkOutput("rst_rs_xy", 32'({x_b, y_b}), 0);
    checkOutput("rst_rs_active", 32'(act_b), 1);
    checkOutput("rst_rs_syncs", 32'({hs_b, vs_b}), 0);
    checkOutput("rst_rs_fc", 32'(fc_b), 0);
    checkOutput("rst_rs_strobes", 32'({ls_b, fs_b, vb_b}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator. It is the next generation of the fixed 640x480 controller: porch, sync and active widths and sync polarity are all parameters, and it adds a run/freeze control, a resync input, line, frame and vblank strobes, and a frame counter. It sits between the clock/pixel-enable source and the sprite/game renderers, which consume x, y, active and the strobes.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 0, hsync asserted level (0 = active-low)
VS_POL, 0, vsync asserted level
X_W, 10, x width; must hold H_TOTAL-1
Y_W, 10, y width; must hold V_TOTAL-1
FRAME_W, 16, frame counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
pix_en  in  1  pixel-rate enable, one clk wide
run  in  1  1 = advance on pix_en; 0 = freeze
resync  in  1  force raster to (0,0) on next clk
hsync  out  1  horizontal sync, polarity HS_POL
vsync  out  1  vertical sync, polarity VS_POL
active  out  1  current pixel is visible
x  out  X_W  horizontal counter h_cnt
y  out  Y_W  vertical counter v_cnt
line_start  out  1  one-clk pulse when h_cnt becomes 0
frame_start  out  1  one-clk pulse when (h_cnt,v_cnt) becomes (0,0)
vblank_start  out  1  one-clk pulse when counters become (0,V_ACTIVE)
frame_count  out  FRAME_W  completed frames, wraps modulo 2^FRAME_W

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Line order: active, front porch, sync, back porch. Counters start at 0 on the first active pixel.
- Advance condition: pix_en & run & ~resync.
  - h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps V_TOTAL-1 -> 0 on that same edge.
- Every output is registered and updates on the same clk edge as the counters. Outputs always describe the current (h_cnt,v_cnt). Latency from a pix_en edge to the outputs is 0 relative to the counters.
- active = (h_cnt < H_ACTIVE) & (v_cnt < V_ACTIVE).
- hsync = HS_POL while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
- vsync: same rule on v_cnt with the V_* parameters and VS_POL. vsync therefore changes only on line boundaries.
- x and y are the raw counters at all times, including blanking. Renderers gate on active.
- Strobes are high for exactly one clk, on the edge that produces the stated counter value, whether by advance or by resync.
  - resync pulses line_start and frame_start.
  - Holding (0,0) for several clks does not repeat a pulse.
- frame_count increments on each frame_start caused by an advance wrap. A resync does not increment it.
- run=0: counters, syncs, active and frame_count hold; strobes are 0. Resuming continues from the held position.
- resync=1: next clk sets h_cnt=0, v_cnt=0, regardless of pix_en and run. frame_count holds.
- Priority: rst > resync > advance.
- Reset state:
  - Counters and frame_count = 0.
  - active=1, x=0, y=0.
  - hsync=~HS_POL, vsync=~VS_POL.
  - All strobes 0.
- Reset mid-frame takes effect on the next clk edge, with no partial-line completion.
- pix_en high every clk is legal (the generator runs at clk rate).
- Elaboration check: each timing parameter ≥1; 2^X_W ≥ H_TOTAL; 2^Y_W ≥ V_TOTAL.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480@60 constant set;
  - derived totals and sync start/end functions;
  - an optional 800x600 constant set for later modes.
- One natural sub-module, vga_axis_counter, instantiated twice (horizontal and vertical). It is parametrised by ACTIVE/FP/SYNC/BP/POL/W.
  - Inputs: step, clear.
  - Outputs: count, wrap, active, sync.
  - The vertical instance's step is the horizontal wrap & advance.
- Strobe and frame-counter logic stays in the top level.

Test Plan:
- Reset: assert rst for 3 clks, with pix_en each clk -> x=0, y=0, active=1, hsync=1, vsync=1, frame_count=0, no strobes.
- Line timing, pix_en every 4th clk, defaults:
  - hsync low for exactly 96 pix_en (384 clk), starting at x=656;
  - active falls at x=640;
  - line_start pulses once per 800 pix_en.
- Frame wrap: run to (799,524), then one pix_en -> (0,0), frame_start=1 for one clk, frame_count 0->1.
  - vblank_start pulses at (0,480).
  - vsync low on lines 490-491 only.
- Small config (H 8/2/2/2, V 4/1/1/1, HS_POL=VS_POL=1), pix_en every clk:
  - hsync high for h=10-11;
  - frame period 14*7=98 clk;
  - frame_count=3 after 294 clk.
- Control:
  - resync at (300,100) -> next clk (0,0), line_start and frame_start pulse, frame_count unchanged;
  - run=0 for 50 clks -> all outputs frozen, then advance resumes from the same position;
  - resync and rst together -> reset state.
